// File: rtl/dcache_responder_if.sv
// D-side request bus plus physical-memory line port of dcache_responder.
// The slave modport is the cache; the master modport is the pipeline/memory side.
interface dcache_responder_if;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with 256-bit line fill/evict.
// Define DCACHE_PERF_COUNTERS_EN to add hit/miss/writeback counters.
module dcache_responder #(
    parameter int S_INDEX = 3
) (
    input  logic               clk,
    input  logic               rst,
    dcache_responder_if.slave  bus
`ifdef DCACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count,
    output logic [31:0]        wb_count
`endif
);
    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} state_t;

    state_t state, state_next;

    logic [SETS-1:0]    valid;
    logic [SETS-1:0]    dirty;
    logic [TAG_W-1:0]   tags  [SETS];
    logic [255:0]       lines [SETS];

    logic [S_INDEX-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         word_sel;
    logic               req;
    logic               hit;
    logic               write_hit;
    logic               wb_done;
    logic               fill_done;
    logic               mem_resp;
    logic               pmem_read;
    logic               pmem_write;
    logic [31:0]        pmem_address;
    logic               unused_addr_lsbs;

    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] w;
        w = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) w[8*i +: 8] = new_word[8*i +: 8];
        end
        return w;
    endfunction

    assign idx              = bus.mem_address[4+S_INDEX:5];
    assign req_tag          = bus.mem_address[31:5+S_INDEX];
    assign word_sel         = bus.mem_address[4:2];
    assign unused_addr_lsbs = ^bus.mem_address[1:0];

    // A simultaneous read+write is illegal; mem_write takes precedence below.
    assign req       = bus.mem_read | bus.mem_write;
    assign hit       = valid[idx] && (tags[idx] == req_tag);
    assign write_hit = (state == CHECK) && bus.mem_write && hit;
    assign wb_done   = (state == WRITEBACK) && bus.pmem_resp;
    assign fill_done = (state == FILL) && bus.pmem_resp;

    assign bus.mem_rdata    = lines[idx][{word_sel, 5'd0} +: 32];
    assign bus.mem_resp     = mem_resp;
    assign bus.pmem_read    = pmem_read;
    assign bus.pmem_write   = pmem_write;
    assign bus.pmem_address = pmem_address;
    assign bus.pmem_wdata   = lines[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CHECK;
        else      state <= state_next;
    end

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {bus.mem_address[31:5], 5'd0};
        case (state)
            CHECK: begin
                if (req) begin
                    if (hit)                           mem_resp   = 1'b1;
                    else if (valid[idx] && dirty[idx]) state_next = WRITEBACK;
                    else                               state_next = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tags[idx], idx, 5'd0};
                if (bus.pmem_resp) state_next = FILL;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (bus.pmem_resp) state_next = CHECK;
            end
            default: state_next = CHECK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_done) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (wb_done) begin
            dirty[idx] <= 1'b0;
        end else if (write_hit && (bus.mem_byte_enable != 4'd0)) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Line data and tags carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            lines[idx] <= bus.pmem_rdata;
            tags[idx]  <= req_tag;
        end else if (write_hit) begin
            lines[idx][{word_sel, 5'd0} +: 32] <=
                merge_word(lines[idx][{word_sel, 5'd0} +: 32], bus.mem_wdata, bus.mem_byte_enable);
        end
    end

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
                                     !(bus.mem_read && bus.mem_write));

`ifdef DCACHE_PERF_COUNTERS_EN
    // missed_req marks the retried response after a fill so it is not counted as a hit.
    logic missed_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
            wb_count   <= 32'd0;
            missed_req <= 1'b0;
        end else begin
            if (mem_resp && !missed_req) hit_count <= hit_count + 32'd1;
            if (wb_done)                 wb_count  <= wb_count + 32'd1;
            if ((state == CHECK) && (state_next != CHECK)) begin
                miss_count <= miss_count + 32'd1;
                missed_req <= 1'b1;
            end else if ((state == CHECK) && (!req || mem_resp)) begin
                missed_req <= 1'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// Randomized self-checking bench for dcache_responder against a set/line-level cache model.
// Also exercises the DCACHE_PERF_COUNTERS_EN ports when that macro is defined.
module tb_dcache_responder;
    localparam int S_INDEX = 3;
    localparam int SETS    = 1 << S_INDEX;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_responder_if bus();

`ifdef DCACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    dcache_responder #(.S_INDEX(S_INDEX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DCACHE_PERF_COUNTERS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: backing memory by line address plus per-set cache contents.
    logic [255:0] bmem [logic [26:0]];
    bit           mvalid [SETS];
    bit           mdirty [SETS];
    logic [26:0]  mline_addr [SETS];
    logic [255:0] mdata [SETS];
    int           m_hits, m_miss, m_wb;
    int           max_lat = 0;

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            mvalid[s] = 1'b0;
            mdirty[s] = 1'b0;
        end
        m_hits = 0;
        m_miss = 0;
        m_wb   = 0;
    endtask

    task automatic access(input logic [31:0] addr, input bit wr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rdata, output bit was_hit,
                          output int n_wb, output logic [255:0] wb_data);
        int          set, cyc, fill_cyc, lat, wait_cnt, w, exp_cyc;
        bit          done, exp_hit, exp_wb;
        logic [26:0] laddr;
        laddr   = addr[31:5];
        set     = int'(laddr % SETS);
        w       = int'(addr[4:2]);
        exp_hit = mvalid[set] && (mline_addr[set] == laddr);
        exp_wb  = !exp_hit && mvalid[set] && mdirty[set];
        if (!bmem.exists(laddr)) bmem[laddr] = rand_line();
        rdata = '0; was_hit = 0; n_wb = 0; wb_data = '0;
        done = 0; cyc = 0; fill_cyc = -10; wait_cnt = 0;
        lat = $urandom_range(max_lat, 0);

        @(posedge clk); #1;
        bus.mem_address     = addr;
        bus.mem_read        = !wr;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;

        while (!done && cyc < 100) begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (bus.mem_resp) begin
                done    = 1;
                was_hit = (cyc == 0);
                rdata   = bus.mem_rdata;
                exp_cyc = exp_hit ? 0 : fill_cyc + 1;
                n_checks++;
                if (cyc !== exp_cyc) begin
                    n_fail++;
                    $display("FAIL resp_latency addr=%h got cycle %0d expected cycle %0d", addr, cyc, exp_cyc);
                end
                n_checks++;
                if (n_wb !== (exp_wb ? 1 : 0)) begin
                    n_fail++;
                    $display("FAIL writeback_count addr=%h got %0d expected %0d", addr, n_wb, exp_wb ? 1 : 0);
                end
            end else if (bus.pmem_write) begin
                if (wait_cnt == lat) begin
                    n_checks++;
                    if (bus.pmem_address !== {mline_addr[set], 5'd0}) begin
                        n_fail++;
                        $display("FAIL wb_address got %h expected %h", bus.pmem_address, {mline_addr[set], 5'd0});
                    end
                    n_checks++;
                    if (bus.pmem_wdata !== mdata[set]) begin
                        n_fail++;
                        $display("FAIL wb_data got %h expected %h", bus.pmem_wdata, mdata[set]);
                    end
                    wb_data       = bus.pmem_wdata;
                    n_wb++;
                    bus.pmem_resp = 1'b1;
                    wait_cnt      = 0;
                end else wait_cnt++;
            end else if (bus.pmem_read) begin
                if (wait_cnt == lat) begin
                    n_checks++;
                    if (bus.pmem_address !== {laddr, 5'd0}) begin
                        n_fail++;
                        $display("FAIL fill_address got %h expected %h", bus.pmem_address, {laddr, 5'd0});
                    end
                    bus.pmem_rdata = bmem[laddr];
                    bus.pmem_resp  = 1'b1;
                    fill_cyc       = cyc;
                    wait_cnt       = 0;
                end else wait_cnt++;
            end
            cyc++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL resp_timeout addr=%h got no mem_resp expected one within 100 cycles", addr);
        end

        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;

        if (exp_hit) m_hits++;
        else begin
            m_miss++;
            if (exp_wb) begin
                bmem[mline_addr[set]] = mdata[set];
                m_wb++;
            end
            mdata[set]      = bmem[laddr];
            mline_addr[set] = laddr;
            mvalid[set]     = 1'b1;
            mdirty[set]     = 1'b0;
        end
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mdata[set][32*w + 8*b +: 8] = wd[8*b +: 8];
            if (be != 4'd0) mdirty[set] = 1'b1;
        end else begin
            n_checks++;
            if (rdata !== mdata[set][32*w +: 32]) begin
                n_fail++;
                $display("FAIL read_data addr=%h got %h expected %h", addr, rdata, mdata[set][32*w +: 32]);
            end
        end
    endtask

    task automatic test_perf();
`ifdef DCACHE_PERF_COUNTERS_EN
        n_checks++;
        if (hit_count !== 32'(m_hits)) begin
            n_fail++;
            $display("FAIL hit_count got %0d expected %0d", hit_count, m_hits);
        end
        n_checks++;
        if (miss_count !== 32'(m_miss)) begin
            n_fail++;
            $display("FAIL miss_count got %0d expected %0d", miss_count, m_miss);
        end
        n_checks++;
        if (wb_count !== 32'(m_wb)) begin
            n_fail++;
            $display("FAIL wb_count got %0d expected %0d", wb_count, m_wb);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.mem_address = 32'h1234_5678;
        bus.mem_read    = 1'b1;
        #12;
        n_checks++;
        if (bus.mem_resp !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_resp got %b expected 0", bus.mem_resp);
        end
        n_checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_pmem_strobes got r=%b w=%b expected 0/0", bus.pmem_read, bus.pmem_write);
        end
        n_checks++;
        if (bus.pmem_address !== 32'h1234_5660) begin
            n_fail++; $display("FAIL reset_pmem_address got %h expected 12345660", bus.pmem_address);
        end
        bus.mem_read = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        test_perf();
    endtask

    task automatic test_fill();
        logic [255:0] l; logic [31:0] rd; bit h; int nw; logic [255:0] wbd;
        l = rand_line();
        l[31:0]  = 32'hDEAD_BEEF;
        l[63:32] = 32'h1111_1111;
        bmem[27'h8] = l;
        access(32'h100, 0, 4'h0, 32'h0, rd, h, nw, wbd);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF || h !== 1'b0 || nw !== 0) begin
            n_fail++; $display("FAIL fill_read got data=%h hit=%b wb=%0d expected deadbeef/0/0", rd, h, nw);
        end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; bit h; int nw; logic [255:0] wbd;
        access(32'h104, 1, 4'b0011, 32'h1234_ABCD, rd, h, nw, wbd);
        n_checks++;
        if (h !== 1'b1) begin
            n_fail++; $display("FAIL write_hit got hit=%b expected 1", h);
        end
        access(32'h104, 0, 4'h0, 32'h0, rd, h, nw, wbd);
        n_checks++;
        if (rd !== 32'h1111_ABCD || h !== 1'b1) begin
            n_fail++; $display("FAIL write_then_read got data=%h hit=%b expected 1111abcd/1", rd, h);
        end
        access(32'h108, 1, 4'b0000, 32'hFFFF_FFFF, rd, h, nw, wbd);
        access(32'h108, 0, 4'h0, 32'h0, rd, h, nw, wbd);
    endtask

    task automatic test_dirty_evict();
        logic [31:0] rd; bit h; int nw; logic [255:0] wbd;
        access(32'h200, 0, 4'h0, 32'h0, rd, h, nw, wbd);
        n_checks++;
        if (nw !== 1 || wbd[63:32] !== 32'h1111_ABCD) begin
            n_fail++; $display("FAIL dirty_evict got wb=%0d word1=%h expected 1/1111abcd", nw, wbd[63:32]);
        end
        test_perf();
    endtask

    task automatic test_clean_evict();
        logic [31:0] rd; bit h; int nw; logic [255:0] wbd;
        access(32'h100, 0, 4'h0, 32'h0, rd, h, nw, wbd);
        access(32'h200, 0, 4'h0, 32'h0, rd, h, nw, wbd);
        n_checks++;
        if (nw !== 0 || h !== 1'b0) begin
            n_fail++; $display("FAIL clean_evict got wb=%0d hit=%b expected 0/0", nw, h);
        end
    endtask

    task automatic test_reset_mid_fill();
        int cyc; bit seen; logic [31:0] rd; bit h; int nw; logic [255:0] wbd;
        cyc = 0; seen = 0;
        @(posedge clk); #1;
        bus.mem_address = 32'h100;
        bus.mem_read    = 1'b1;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            if (bus.pmem_read) seen = 1;
            cyc++;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL mid_fill_start got pmem_read=0 expected 1 within 20 cycles");
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0) begin
            n_fail++; $display("FAIL mid_fill_reset got pmem_read=%b mem_resp=%b expected 0/0", bus.pmem_read, bus.mem_resp);
        end
        @(posedge clk); #1;
        bus.mem_read = 1'b0;
        rst = 1'b1;
        model_reset();
        test_perf();
        access(32'h100, 0, 4'h0, 32'h0, rd, h, nw, wbd);
        n_checks++;
        if (h !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_read got hit=%b expected 0", h);
        end
    endtask

    task automatic test_pmem_resp_idle();
        logic [31:0] rd; bit h; int nw; logic [255:0] wbd;
        @(posedge clk); #1;
        bus.pmem_resp = 1'b1;
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
        access(32'h11C, 0, 4'h0, 32'h0, rd, h, nw, wbd);
        n_checks++;
        if (h !== 1'b1) begin
            n_fail++; $display("FAIL idle_pmem_resp got hit=%b expected 1", h);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; bit h; int nw; logic [255:0] wbd;
        logic [26:0] laddr; logic [31:0] addr;
        max_lat = 3;
        for (int i = 0; i < 200; i++) begin
            laddr = 27'(($urandom_range(3, 0) << S_INDEX) | $urandom_range(SETS - 1, 0));
            if ($urandom_range(3, 0) == 0) laddr[26] = 1'b1;
            addr = {laddr, 3'($urandom_range(7, 0)), 2'b00};
            access(addr, $urandom_range(1, 0) == 1, 4'($urandom), $urandom, rd, h, nw, wbd);
        end
        test_perf();
    endtask

    initial begin
        bus.mem_address     = '0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata       = '0;
        bus.pmem_rdata      = '0;
        bus.pmem_resp       = 1'b0;
        test_reset();
        test_fill();
        test_write_hit();
        test_dirty_evict();
        test_clean_evict();
        test_reset_mid_fill();
        test_pmem_resp_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Direct-mapped, write-back, write-allocate data cache answering the pipeline's D-side requests (mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata).
- Fills and evicts whole 256-bit lines through a physical-memory port.
- Sits between the datapath MEM stage and the cacheline adapter/arbiter.
- Adds the mem_resp handshake the pipeline uses to stall MEM until the access completes.

Parameters:
- S_INDEX, 3, number of index bits; sets = 2**S_INDEX (default 8).
- Fixed, not parameters: line = 256 bits (32 B), offset = 5 bits, tag = 32-5-S_INDEX bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_address  in  32  byte address; [4:2] selects the word, [4+S_INDEX:5] the index, the rest the tag.
- mem_read  in  1  read request; held stable until mem_resp.
- mem_write  in  1  write request; held stable until mem_resp.
- mem_byte_enable  in  4  write lane enables; bit i covers bits [8i+7:8i].
- mem_wdata  in  32  write data, lane-aligned.
- mem_rdata  out  32  aligned word from the line; valid only while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  32  line address; [4:0] always 0.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line writeback request; held until pmem_resp.
- pmem_wdata  out  256  victim line.
- pmem_rdata  in  256  fill line; valid when pmem_resp=1.
- pmem_resp  in  1  one-cycle completion from memory.

Behaviour:
- Storage: per set valid, dirty, tag (flops) and a 256-bit data line. Only valid and dirty are reset; data and tag are not.
- Reset (rst=0, asynchronous): state <= CHECK, all valid/dirty <= 0.
  - Outputs in reset: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address={mem_address[31:5],5'b0}.
- FSM states:
  - CHECK (idle + tag compare).
    - No request: all strobes 0.
    - Request and hit (valid && tag match): mem_resp=1 in the same cycle (combinational); stay in CHECK.
    - Write hit: enabled lanes of the selected word are updated at that edge; dirty <= 1 if mem_byte_enable != 0. Enable 0000 still responds with no change.
    - Miss with victim dirty: go to WRITEBACK. Miss with victim clean or invalid: go to FILL. No mem_resp on a miss.
  - WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line. On pmem_resp: dirty <= 0, go to FILL.
  - FILL: pmem_read=1, pmem_address={req tag, index, 5'b0}. On pmem_resp: line <= pmem_rdata, tag <= req tag, valid <= 1, dirty <= 0, go to CHECK. The retried request then hits.
- Latency:
  - Hit: 0 cycles (mem_resp in the request cycle).
  - Clean miss: mem_resp one cycle after pmem_resp.
  - Dirty miss: writeback plus fill, then one cycle.
- mem_read and mem_write both high: illegal; an assertion fires and the access is treated as a write.
- Request dropped mid-miss: the in-flight pmem transaction still completes, then the FSM returns to CHECK.
- pmem_resp in CHECK: ignored.
- Reset mid-WRITEBACK/FILL: pmem strobes drop immediately (asynchronously); the line being filled stays invalid.
- Address wrap: the index uses only bits [4+S_INDEX:5]; addresses that differ only in tag map to the same set.

Optional Feature:
- Macro DCACHE_PERF_COUNTERS_EN.
- When defined: adds outputs hit_count, miss_count, wb_count (32 bits each). All reset to 0.
  - hit_count increments on each hit response.
  - miss_count increments on each CHECK->WRITEBACK/FILL transition.
  - wb_count increments on each pmem_resp in WRITEBACK.
  - All counters wrap at 2**32.
- When undefined: these ports and the counter logic do not exist; behaviour is otherwise identical.

Test Plan:
- After reset, read 0x100 -> pmem_read=1 with pmem_address=0x100. Return a line with word0=0xDEADBEEF. Next cycle: mem_resp=1, mem_rdata=0xDEADBEEF; pmem_write never asserted.
- After filling 0x104 with 0x11111111, write 0x1234ABCD to 0x104 with be=0011, then read 0x104 -> mem_rdata=0x1111ABCD, both hits with mem_resp in the request cycle, no pmem traffic.
- Dirty eviction: dirty line at 0x100, then read 0x200 (same set at S_INDEX=3) -> pmem_write at 0x100 with the modified word in pmem_wdata[63:32], then pmem_read at 0x200, then mem_resp.
- Clean eviction: read 0x100, then read 0x200 -> no pmem_write; only pmem_read at 0x200.
- Reset mid-FILL: pull rst low while pmem_read=1 -> pmem_read=0 the same cycle. After release, reading 0x100 misses again.
- With DCACHE_PERF_COUNTERS_EN, run scenarios 1-3 in sequence from reset -> hit_count=2, miss_count=2, wb_count=1.
